term_ctrl: RTL and testbench
============================

TERM_CTRL -- requirements
Module: term_ctrl

Interface
REQ-001 SHALL have parameter STROBE_LEN, default 4, dstrobe high time in clk cycles (range 1-15).
REQ-002 SHALL have port clk  input  1  system clock (100 MHz).
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port rx_data  input  8  incoming byte stream.
REQ-005 SHALL have port rx_valid  input  1  rx_data is valid.
REQ-006 SHALL have port rx_ready  output  1  byte accepted when rx_valid && rx_ready at a clk edge.
REQ-007 SHALL have port currow  input  5  cursor row fed back from terminal (0-29).
REQ-008 SHALL have port curcol  input  7  cursor column fed back from terminal (0-79).
REQ-009 SHALL have port data  output  8  payload to terminal.
REQ-010 SHALL have port dtype  output  2  payload type: 0 = char, 1 = column, 2 = row.
REQ-011 SHALL have port dstrobe  output  1  terminal latches data/dtype on its rising edge.
REQ-012 SHALL have port busy  output  1  high whenever the state is not IDLE, ESC, ESC_ROW or ESC_COL.

Function
REQ-013 SHALL use states IDLE, ESC, ESC_ROW, ESC_COL, SETUP, STROBE, HOLD and CLR.
REQ-014 SHALL assert rx_ready only in IDLE, ESC, ESC_ROW and ESC_COL.
REQ-015 SHALL run each terminal write as: SETUP 1 cycle (data/dtype driven, dstrobe=0), then STROBE for STROBE_LEN cycles (dstrobe=1), then HOLD 1 cycle (dstrobe=0); data/dtype stay constant across all three phases.
REQ-016 SHALL sample currow/curcol only in IDLE, ESC, ESC_ROW or ESC_COL, never during a write.
REQ-017 SHALL make a one-write command drop rx_ready for exactly STROBE_LEN+2 cycles after the accept edge.
REQ-018 SHALL map each accepted byte in IDLE as follows:
- 0x20-0x7E: one write, dtype 0, data = byte.
- CR 0x0D: one write, dtype 1, data 0.
- LF 0x0A: one write, dtype 2, data = currow+1, or 0 when currow==29 (wrap, no scroll).
- BS 0x08: one write, dtype 1, data = curcol-1 when curcol>0; when curcol==0, no write and byte discarded.
- FF 0x0C: clear-screen sequence per REQ-020.
- ESC 0x1B: transition to ESC, no write.
- Every other byte (including 0x7F): discarded, 1 cycle, no write.
REQ-019 SHALL handle escape sequences as follows:
- In ESC: 'Y' (0x59) moves to ESC_ROW; any other byte is discarded and returns to IDLE.
- ESC_ROW latches r = byte-0x20, clamped to 29; ESC_COL latches c = byte-0x20, clamped to 79.
- Then emits row write (dtype 2, data r) followed by column write (dtype 1, data c).
- Bytes below 0x20 in ESC_ROW/ESC_COL are treated as 0.
REQ-020 SHALL perform FF as: dtype 2 data 0, then dtype 1 data 0, then 2400 writes dtype 0 data 0x20 counted by a 12-bit counter in CLR; the final cursor position is (0,0) via terminal wrap.
REQ-021 SHALL keep rx_ready at 0 throughout the whole FF sequence, with no input bytes lost or reordered.

Reset
REQ-022 SHALL force, while reset_n=0: state IDLE, data 0, dtype 0, dstrobe 0, rx_ready 0, busy 0, counters 0.
REQ-023 SHALL abort any sequence on reset mid-operation (write, escape or clear), with dstrobe falling immediately; rx_ready SHALL assert on the first clk edge after reset_n rises.

Configuration
REQ-024 SHALL handle HT 0x09, when TERM_TAB_EN is defined, as one write dtype 1, data = min((curcol|7)+1, 79).
REQ-025 SHALL discard HT like any other unsupported control byte when TERM_TAB_EN is not defined.

Structure
REQ-026 SHALL place the state encoding, character constants (CR, LF, BS, FF, ESC, HT, SPACE), dtype codes, ROWS=30, COLS=80 and CLR_COUNT=2400 in shared package term_pkg.
REQ-027 SHALL implement the SETUP/STROBE/HOLD sequencer as sub-module term_strobe (inputs start, wdata, wtype; output done).

Verification (STROBE_LEN=4)
REQ-028 SHALL check that 'A' (0x41) accepted at edge k gives data=0x41, dtype=0 at k+1, dstrobe high k+2..k+5, and rx_ready high again at k+7.
REQ-029 SHALL check that LF with currow=29 gives dtype 2, data 0, and that BS with curcol=0 gives no dstrobe pulse.
REQ-030 SHALL check that ESC 'Y' 0x25 0x7F gives a row write of 5 then a column write of 79 (clamped).
REQ-031 SHALL check that FF gives exactly 2402 dstrobe pulses, the last 2400 with data 0x20, with rx_ready low throughout.
REQ-032 SHALL check that reset_n pulsed low during the STROBE phase drops dstrobe the same instant, and that 'B' is then written normally.
REQ-033 SHALL check that HT with curcol=77 writes column 79 with TERM_TAB_EN defined, and gives no pulse without it.

Source files
------------

// File: rtl/term_pkg.sv
// Shared types and constants for the terminal byte-stream controller.
package term_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ESC,
        ST_ESC_ROW,
        ST_ESC_COL,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_CLR
    } state_t;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_STROBE,
        PH_HOLD
    } phase_t;

    typedef enum logic [1:0] {
        SEQ_NONE,
        SEQ_COL,
        SEQ_FF_COL,
        SEQ_CLR
    } seq_t;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_HT    = 8'h09;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_ESC   = 8'h1B;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_Y     = 8'h59;
    localparam logic [7:0] CH_TILDE = 8'h7E;

    localparam logic [1:0] DT_CHAR = 2'd0;
    localparam logic [1:0] DT_COL  = 2'd1;
    localparam logic [1:0] DT_ROW  = 2'd2;

    localparam int ROWS      = 30;
    localparam int COLS      = 80;
    localparam int CLR_COUNT = 2400;

    localparam logic [7:0]  ROW_MAX  = 8'(ROWS - 1);
    localparam logic [7:0]  COL_MAX  = 8'(COLS - 1);
    localparam logic [11:0] CLR_LAST = 12'(CLR_COUNT);

    // Escape coordinates are biased by 0x20; control bytes map to 0.
    function automatic logic [7:0] esc_pos(
        input logic [7:0] b,
        input logic [7:0] lim
    );
        logic [7:0] v;
        v = (b < CH_SPACE) ? 8'd0 : b - CH_SPACE;
        return (v > lim) ? lim : v;
    endfunction

    function automatic logic is_rx_state(input state_t s);
        return (s == ST_IDLE) || (s == ST_ESC) ||
               (s == ST_ESC_ROW) || (s == ST_ESC_COL);
    endfunction

endpackage

// File: rtl/term_strobe.sv
// Terminal write sequencer: SETUP, STROBE_LEN cycles of STROBE, HOLD.
// data/dtype are latched on start and held until the next start.
module term_strobe
    import term_pkg::*;
#(
    parameter int STROBE_LEN = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] wdata,
    input  logic [1:0] wtype,
    output logic [7:0] data,
    output logic [1:0] dtype,
    output logic       dstrobe,
    output logic       last,
    output logic       done
);

    localparam logic [3:0] CNT_LAST = 4'(STROBE_LEN - 1);

    phase_t     phase_q, phase_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] data_q, data_d;
    logic [1:0] type_q, type_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= PH_IDLE;
            cnt_q   <= 4'd0;
            data_q  <= 8'd0;
            type_q  <= 2'd0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            type_q  <= type_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        type_d  = type_q;
        if (start) begin
            phase_d = PH_SETUP;
            cnt_d   = 4'd0;
            data_d  = wdata;
            type_d  = wtype;
        end else begin
            unique case (phase_q)
                PH_SETUP: begin
                    phase_d = PH_STROBE;
                    cnt_d   = 4'd0;
                end
                PH_STROBE: begin
                    if (cnt_q == CNT_LAST) phase_d = PH_HOLD;
                    else cnt_d = cnt_q + 4'd1;
                end
                PH_HOLD: phase_d = PH_IDLE;
                default: ;
            endcase
        end
    end

    // Decoded straight from the phase flop so reset drops dstrobe at once.
    always_comb begin
        data    = data_q;
        dtype   = type_q;
        dstrobe = (phase_q == PH_STROBE);
        last    = (phase_q == PH_STROBE) && (cnt_q == CNT_LAST);
        done    = (phase_q == PH_HOLD);
    end

endmodule

// File: rtl/term_ctrl.sv
// Byte-stream to terminal-write controller with ESC Y cursor addressing.
// Optional: define TERM_TAB_EN to expand HT to the next 8-column stop.
module term_ctrl
    import term_pkg::*;
#(
    parameter int STROBE_LEN = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    input  logic [4:0] currow,
    input  logic [6:0] curcol,
    output logic [7:0] data,
    output logic [1:0] dtype,
    output logic       dstrobe,
    output logic       busy
);

    state_t      state_q, state_d;
    seq_t        seq_q, seq_d;
    logic [11:0] cnt_q, cnt_d;
    logic [7:0]  row_q, row_d;
    logic [7:0]  col_q, col_d;
    logic        rx_ready_q, rx_ready_d;

    logic        accept;
    logic        start;
    logic [7:0]  wdata;
    logic [1:0]  wtype;
    logic        str_last;
    logic        str_done;
    logic [7:0]  lf_row;
`ifdef TERM_TAB_EN
    logic [7:0]  tab_col;
`endif

    assign accept = rx_valid && rx_ready_q;
    assign lf_row = (currow == 5'(ROWS - 1)) ? 8'd0
                  : {3'd0, currow + 5'd1};
`ifdef TERM_TAB_EN
    assign tab_col = ({1'b0, curcol | 7'd7} + 8'd1 > COL_MAX) ? COL_MAX
                   : {1'b0, curcol | 7'd7} + 8'd1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            seq_q      <= SEQ_NONE;
            cnt_q      <= 12'd0;
            row_q      <= 8'd0;
            col_q      <= 8'd0;
            rx_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            seq_q      <= seq_d;
            cnt_q      <= cnt_d;
            row_q      <= row_d;
            col_q      <= col_d;
            rx_ready_q <= rx_ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        col_d   = col_q;
        start   = 1'b0;
        wdata   = 8'd0;
        wtype   = DT_CHAR;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    unique case (1'b1)
                        (rx_data >= CH_SPACE) && (rx_data <= CH_TILDE): begin
                            start = 1'b1;
                            wdata = rx_data;
                            wtype = DT_CHAR;
                        end
                        rx_data == CH_CR: begin
                            start = 1'b1;
                            wtype = DT_COL;
                        end
                        rx_data == CH_LF: begin
                            start = 1'b1;
                            wdata = lf_row;
                            wtype = DT_ROW;
                        end
                        rx_data == CH_BS: begin
                            start = (curcol != 7'd0);
                            wdata = {1'b0, curcol - 7'd1};
                            wtype = DT_COL;
                        end
`ifdef TERM_TAB_EN
                        rx_data == CH_HT: begin
                            start = 1'b1;
                            wdata = tab_col;
                            wtype = DT_COL;
                        end
`endif
                        rx_data == CH_FF: begin
                            start = 1'b1;
                            wtype = DT_ROW;
                            seq_d = SEQ_FF_COL;
                            cnt_d = 12'd0;
                        end
                        rx_data == CH_ESC: state_d = ST_ESC;
                        default: ;
                    endcase
                    if (start) state_d = ST_SETUP;
                end
            end
            ST_ESC: begin
                if (accept) begin
                    state_d = (rx_data == CH_Y) ? ST_ESC_ROW : ST_IDLE;
                end
            end
            ST_ESC_ROW: begin
                if (accept) begin
                    row_d   = esc_pos(rx_data, ROW_MAX);
                    state_d = ST_ESC_COL;
                end
            end
            ST_ESC_COL: begin
                if (accept) begin
                    col_d   = esc_pos(rx_data, COL_MAX);
                    start   = 1'b1;
                    wdata   = row_q;
                    wtype   = DT_ROW;
                    seq_d   = SEQ_COL;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: state_d = ST_STROBE;
            ST_STROBE: begin
                if (str_last) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (str_done) begin
                    unique case (seq_q)
                        SEQ_COL, SEQ_FF_COL: begin
                            start   = 1'b1;
                            wdata   = (seq_q == SEQ_COL) ? col_q : 8'd0;
                            wtype   = DT_COL;
                            seq_d   = (seq_q == SEQ_COL) ? SEQ_NONE : SEQ_CLR;
                            state_d = ST_SETUP;
                        end
                        SEQ_CLR: state_d = ST_CLR;
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
            ST_CLR: begin
                if (cnt_q == CLR_LAST) begin
                    seq_d   = SEQ_NONE;
                    state_d = ST_IDLE;
                end else begin
                    start   = 1'b1;
                    wdata   = CH_SPACE;
                    wtype   = DT_CHAR;
                    cnt_d   = cnt_q + 12'd1;
                    state_d = ST_SETUP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // rx_ready is registered so it stays low while reset_n is asserted.
    always_comb begin
        rx_ready_d = is_rx_state(state_d);
        rx_ready   = rx_ready_q;
        busy       = !is_rx_state(state_q);
    end

    term_strobe #(
        .STROBE_LEN(STROBE_LEN)
    ) u_strobe (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .wdata  (wdata),
        .wtype  (wtype),
        .data   (data),
        .dtype  (dtype),
        .dstrobe(dstrobe),
        .last   (str_last),
        .done   (str_done)
    );

endmodule

// File: tb/tb_term_ctrl.sv
// Directed bench for term_ctrl with STROBE_LEN=4.
module tb_term_ctrl;

    logic       clk;
    logic       reset_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [4:0] currow;
    logic [6:0] curcol;
    logic [7:0] data;
    logic [1:0] dtype;
    logic       dstrobe;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0] p_dt[$];
    logic [7:0] p_dd[$];

    typedef struct {
        logic [7:0] b;
        logic [4:0] row;
        logic [6:0] col;
        int         np;
        logic [1:0] dt;
        logic [7:0] dd;
    } vec_t;

    vec_t vt[$];

    term_ctrl #(.STROBE_LEN(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .currow  (currow),
        .curcol  (curcol),
        .data    (data),
        .dtype   (dtype),
        .dstrobe (dstrobe),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int w;
        w = 0;
        @(negedge clk);
        while (!rx_ready && w < 30000) begin
            @(negedge clk);
            w++;
        end
        chk("send_ready_wait", rx_ready, 1);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic collect(input int bound);
        int   cyc;
        logic prev;
        p_dt.delete();
        p_dd.delete();
        prev = 1'b0;
        cyc  = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (dstrobe && !prev) begin
                p_dt.push_back(dtype);
                p_dd.push_back(data);
            end
            prev = dstrobe;
        end while (!rx_ready && cyc < bound);
        chk("collect_ready_return", rx_ready, 1);
    endtask

    initial begin
        int nsp;
        reset_n  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        currow   = 5'd0;
        curcol   = 7'd0;

        // Hand-computed single-byte vectors.
        vt.push_back('{8'h41, 5'd0,  7'd0,  1, 2'd0, 8'h41});
        vt.push_back('{8'h7E, 5'd0,  7'd0,  1, 2'd0, 8'h7E});
        vt.push_back('{8'h20, 5'd0,  7'd0,  1, 2'd0, 8'h20});
        vt.push_back('{8'h0D, 5'd3,  7'd40, 1, 2'd1, 8'h00});
        vt.push_back('{8'h0A, 5'd5,  7'd0,  1, 2'd2, 8'h06});
        vt.push_back('{8'h0A, 5'd29, 7'd0,  1, 2'd2, 8'h00});
        vt.push_back('{8'h08, 5'd0,  7'd10, 1, 2'd1, 8'h09});
        vt.push_back('{8'h08, 5'd0,  7'd0,  0, 2'd0, 8'h00});
        vt.push_back('{8'h7F, 5'd0,  7'd0,  0, 2'd0, 8'h00});
        vt.push_back('{8'h00, 5'd0,  7'd0,  0, 2'd0, 8'h00});
        vt.push_back('{8'h1F, 5'd0,  7'd0,  0, 2'd0, 8'h00});
        vt.push_back('{8'h80, 5'd0,  7'd0,  0, 2'd0, 8'h00});
`ifdef TERM_TAB_EN
        vt.push_back('{8'h09, 5'd0,  7'd77, 1, 2'd1, 8'd79});
        vt.push_back('{8'h09, 5'd0,  7'd3,  1, 2'd1, 8'd8});
`else
        vt.push_back('{8'h09, 5'd0,  7'd77, 0, 2'd0, 8'h00});
        vt.push_back('{8'h09, 5'd0,  7'd3,  0, 2'd0, 8'h00});
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_data", data, 0);
        chk("rst_dtype", dtype, 0);
        chk("rst_dstrobe", dstrobe, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1 chk("rel_ready_before_edge", rx_ready, 0);
        @(posedge clk);
        #1 chk("rel_ready_first_edge", rx_ready, 1);

        foreach (vt[i]) begin
            currow = vt[i].row;
            curcol = vt[i].col;
            send(vt[i].b);
            collect(100);
            chk($sformatf("vec%0d_pulses", i), p_dt.size(), vt[i].np);
            if (p_dt.size() > 0) begin
                chk($sformatf("vec%0d_dtype", i), p_dt[0], vt[i].dt);
                chk($sformatf("vec%0d_data", i), p_dd[0], vt[i].dd);
            end
        end
        currow = 5'd0;
        curcol = 7'd0;

        // Exact cycle timing of a single write.
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = 8'h41;
        @(posedge clk);
        #1 rx_valid = 1'b0;
        chk("t_setup_data", data, 8'h41);
        chk("t_setup_dtype", dtype, 0);
        chk("t_setup_strobe", dstrobe, 0);
        chk("t_setup_ready", rx_ready, 0);
        chk("t_setup_busy", busy, 1);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1 chk($sformatf("t_strobe%0d", i), dstrobe, 1);
            chk($sformatf("t_strobe%0d_data", i), data, 8'h41);
        end
        @(posedge clk);
        #1 chk("t_hold_strobe", dstrobe, 0);
        chk("t_hold_ready", rx_ready, 0);
        chk("t_hold_data", data, 8'h41);
        @(posedge clk);
        #1 chk("t_ready_back", rx_ready, 1);

        // ESC Y with clamping.
        send(8'h1B); collect(100);
        send(8'h59); collect(100);
        send(8'h25); collect(100);
        send(8'h7F); collect(100);
        chk("escy_pulses", p_dt.size(), 2);
        if (p_dt.size() == 2) begin
            chk("escy_row_type", p_dt[0], 2);
            chk("escy_row_data", p_dd[0], 5);
            chk("escy_col_type", p_dt[1], 1);
            chk("escy_col_data", p_dd[1], 79);
        end

        // Control bytes as coordinates read as 0.
        send(8'h1B); collect(100);
        send(8'h59); collect(100);
        send(8'h10); collect(100);
        send(8'h05); collect(100);
        chk("escl_pulses", p_dt.size(), 2);
        if (p_dt.size() == 2) begin
            chk("escl_row_data", p_dd[0], 0);
            chk("escl_col_data", p_dd[1], 0);
        end

        // ESC followed by non-Y is swallowed, then normal again.
        send(8'h1B); collect(100);
        send(8'h41); collect(100);
        chk("escx_pulses", p_dt.size(), 0);
        send(8'h5A); collect(100);
        chk("escx_next_pulses", p_dt.size(), 1);
        if (p_dt.size() == 1) chk("escx_next_data", p_dd[0], 8'h5A);

        // Clear screen; collect ends only when rx_ready returns.
        send(8'h0C);
        collect(30000);
        chk("ff_pulses", p_dt.size(), 2402);
        if (p_dt.size() >= 2) begin
            chk("ff_row_type", p_dt[0], 2);
            chk("ff_row_data", p_dd[0], 0);
            chk("ff_col_type", p_dt[1], 1);
            chk("ff_col_data", p_dd[1], 0);
        end
        nsp = 0;
        for (int i = 2; i < p_dt.size(); i++) begin
            if (p_dt[i] == 2'd0 && p_dd[i] == 8'h20) nsp++;
        end
        chk("ff_spaces", nsp, 2400);
        send(8'h51); collect(100);
        chk("ff_next_pulses", p_dt.size(), 1);
        if (p_dt.size() == 1) chk("ff_next_data", p_dd[0], 8'h51);

        // Reset pulse during STROBE.
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = 8'h43;
        @(posedge clk);
        #1 rx_valid = 1'b0;
        @(posedge clk);
        #1 chk("mr_strobe_on", dstrobe, 1);
        #2 reset_n = 1'b0;
        #1 chk("mr_strobe_off", dstrobe, 0);
        chk("mr_busy", busy, 0);
        chk("mr_ready", rx_ready, 0);
        chk("mr_data", data, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1 chk("mr_ready_back", rx_ready, 1);
        send(8'h42); collect(100);
        chk("mr_b_pulses", p_dt.size(), 1);
        if (p_dt.size() == 1) begin
            chk("mr_b_type", p_dt[0], 0);
            chk("mr_b_data", p_dd[0], 8'h42);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
